// File: rtl/block_mover.sv
// Moving-block controller for one stacker row: slides the block on ticks, latches
// the player's stop, trims it against the tracker's previous block and commits.
module block_mover #(
  parameter int FIELD_W    = 320,
  parameter int CELL_SHIFT = 3,
  parameter int INIT_SIZE  = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       tick,
  input  logic       stop_btn,
  input  logic [8:0] prev_block_start,
  input  logic [8:0] prev_block_end,
  input  logic [3:0] prev_block_size,
  output logic [8:0] curr_block_start,
  output logic [8:0] curr_block_end,
  output logic [3:0] curr_block_size,
  output logic       stop_true,
  output logic       intersect_true,
  output logic       game_over,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MOVE   = 3'd1;
  localparam logic [2:0] S_EVAL   = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_OVER   = 3'd4;

  localparam logic [9:0] CELL = 10'(1 << CELL_SHIFT);
  localparam logic [9:0] LAST = 10'(FIELD_W - 1);

  logic [2:0] state;
  logic       dir_left;
  logic       hit_q;

  // 10-bit views so the +cell bound test cannot wrap
  logic [9:0] s_x, e_x, sz_px, ov_len;
  logic [8:0] ov_s, ov_e;
  logic [3:0] size_sel;
  logic       hit, fits_right, fits_left, pinned;

  assign s_x        = {1'b0, curr_block_start};
  assign e_x        = {1'b0, curr_block_end};
  assign fits_right = (e_x + CELL) <= LAST;
  assign fits_left  = s_x >= CELL;
  assign pinned     = !fits_right && !fits_left;

  assign size_sel = (prev_block_size == 4'd0) ? 4'(INIT_SIZE) : prev_block_size;
  assign sz_px    = 10'(size_sel) << CELL_SHIFT;

  assign ov_s   = (curr_block_start > prev_block_start) ? curr_block_start : prev_block_start;
  assign ov_e   = (curr_block_end < prev_block_end) ? curr_block_end : prev_block_end;
  assign hit    = (prev_block_size == 4'd0) || (ov_s <= ov_e);
  assign ov_len = {1'b0, ov_e} - {1'b0, ov_s} + 10'd1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state            <= S_IDLE;
      dir_left         <= 1'b0;
      hit_q            <= 1'b0;
      curr_block_start <= '0;
      curr_block_end   <= '0;
      curr_block_size  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          curr_block_start <= '0;
          curr_block_end   <= 9'(sz_px - 10'd1);
          curr_block_size  <= size_sel;
          dir_left         <= 1'b0;
          state            <= S_MOVE;
        end
        S_MOVE: begin
          if (stop_btn) begin
            state <= S_EVAL;
          end else if (tick && !pinned) begin
            // bounce turns and steps back in the same tick
            if ((!dir_left && fits_right) || (dir_left && !fits_left)) begin
              curr_block_start <= 9'(s_x + CELL);
              curr_block_end   <= 9'(e_x + CELL);
              dir_left         <= 1'b0;
            end else begin
              curr_block_start <= 9'(s_x - CELL);
              curr_block_end   <= 9'(e_x - CELL);
              dir_left         <= 1'b1;
            end
          end
        end
        S_EVAL: begin
          hit_q <= hit;
          if (hit && prev_block_size != 4'd0) begin
            curr_block_start <= ov_s;
            curr_block_end   <= ov_e;
            curr_block_size  <= 4'(ov_len >> CELL_SHIFT);
          end
          state <= S_COMMIT;
        end
        S_COMMIT: state <= hit_q ? S_IDLE : S_OVER;
        S_OVER:   state <= S_OVER;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign stop_true      = (state == S_COMMIT);
  assign intersect_true = stop_true && hit_q;
  assign game_over      = (state == S_OVER);
  assign busy           = (state == S_MOVE) || (state == S_EVAL) || (state == S_COMMIT);

endmodule

// File: tb/tb_block_mover.sv
// Randomized bench for block_mover; the bench plays the tracker and predicts each
// row from a closed-form bounce position and a max/min overlap.
module tb_block_mover;
  localparam int FIELD_W = 320;
  localparam int CELL    = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0, tick = 1'b0, stop_btn = 1'b0;
  logic [8:0] prev_block_start = '0, prev_block_end = '0;
  logic [3:0] prev_block_size = '0;
  logic [8:0] curr_block_start, curr_block_end;
  logic [3:0] curr_block_size;
  logic       stop_true, intersect_true, game_over, busy;

  int n_cmp = 0;
  int n_err = 0;

  block_mover dut (
    .clk(clk), .resetn(resetn), .start(start), .tick(tick), .stop_btn(stop_btn),
    .prev_block_start(prev_block_start), .prev_block_end(prev_block_end),
    .prev_block_size(prev_block_size),
    .curr_block_start(curr_block_start), .curr_block_end(curr_block_end),
    .curr_block_size(curr_block_size), .stop_true(stop_true),
    .intersect_true(intersect_true), .game_over(game_over), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cell offset after n ticks: a triangle wave between 0 and the rightmost slot.
  function automatic int pos_cells(input int n, input int sz);
    int mx, k;
    mx = FIELD_W / CELL - sz;
    if (mx <= 0) return 0;
    k = n % (2 * mx);
    return (k <= mx) ? k : 2 * mx - k;
  endfunction

  task automatic set_prev(input int s, input int e, input int sz);
    prev_block_start = 9'(s);
    prev_block_end   = 9'(e);
    prev_block_size  = 4'(sz);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step();
    chk("rst_s", int'(curr_block_start), 0);
    chk("rst_e", int'(curr_block_end), 0);
    chk("rst_sz", int'(curr_block_size), 0);
    chk("rst_flags", int'({stop_true, intersect_true, game_over, busy}), 0);
    resetn = 1'b1;
    set_prev(0, 0, 0);
  endtask

  task automatic row(input int nt, input bit stop_tick, input bit poke_start, output bit hit);
    int sz, ex_s, ex_e, ex_sz, os, oe, ps, pe, psz;
    ps = int'(prev_block_start); pe = int'(prev_block_end); psz = int'(prev_block_size);
    sz = (psz == 0) ? 8 : psz;
    start = 1'b1; step(); start = 1'b0;
    chk("start_s", int'(curr_block_start), 0);
    chk("start_e", int'(curr_block_end), sz * CELL - 1);
    chk("start_sz", int'(curr_block_size), sz);
    chk("start_busy", int'(busy), 1);
    for (int n = 1; n <= nt; n++) begin
      repeat ($urandom_range(0, 1)) step();
      tick = 1'b1;
      if (poke_start && n == 1) start = 1'b1;
      step();
      tick = 1'b0; start = 1'b0;
      ex_s = pos_cells(n, sz) * CELL;
      chk("mv_s", int'(curr_block_start), ex_s);
      chk("mv_e", int'(curr_block_end), ex_s + sz * CELL - 1);
    end
    ex_s = pos_cells(nt, sz) * CELL;
    ex_e = ex_s + sz * CELL - 1;
    ex_sz = sz;
    stop_btn = 1'b1; tick = stop_tick; step(); stop_btn = 1'b0; tick = 1'b0;
    chk("eval_s", int'(curr_block_start), ex_s);
    chk("eval_stb", int'(stop_true), 0);
    os = (ex_s > ps) ? ex_s : ps;
    oe = (ex_e < pe) ? ex_e : pe;
    hit = (psz == 0) || (os <= oe);
    if (hit && psz != 0) begin
      ex_s = os; ex_e = oe; ex_sz = (oe - os + 1) / CELL;
    end
    step();
    chk("cm_stb", int'(stop_true), 1);
    chk("cm_hit", int'(intersect_true), int'(hit));
    chk("cm_s", int'(curr_block_start), ex_s);
    chk("cm_e", int'(curr_block_end), ex_e);
    chk("cm_sz", int'(curr_block_size), ex_sz);
    chk("cm_go", int'(game_over), 0);
    step();
    chk("post_stb", int'(stop_true), 0);
    chk("post_go", int'(game_over), int'(!hit));
    chk("post_busy", int'(busy), 0);
    chk("post_s", int'(curr_block_start), ex_s);
    chk("post_e", int'(curr_block_end), ex_e);
    if (hit) set_prev(ex_s, ex_e, ex_sz);
  endtask

  initial begin
    bit h;
    do_reset();
    // base row then trim against it
    row(0, 1'b0, 1'b0, h);
    chk("base_hit", int'(h), 1);
    row(3, 1'b0, 1'b0, h);
    chk("trim_s", int'(prev_block_start), 24);
    chk("trim_sz", int'(prev_block_size), 5);

    // full bounce cycle on the base row
    do_reset();
    row(65, 1'b0, 1'b0, h);

    // tick+stop together at 8/71, start poked while moving
    do_reset();
    set_prev(0, 63, 8);
    row(65, 1'b1, 1'b1, h);
    chk("sim_s", int'(curr_block_start), 8);
    chk("sim_e", int'(curr_block_end), 63);

    // miss, then everything ignored in game over
    do_reset();
    set_prev(0, 15, 2);
    row(2, 1'b0, 1'b0, h);
    chk("miss", int'(h), 0);
    start = 1'b1; tick = 1'b1; stop_btn = 1'b1; step();
    start = 1'b0; tick = 1'b0; stop_btn = 1'b0; step();
    chk("go_sticky", int'(game_over), 1);
    chk("go_busy", int'(busy), 0);
    chk("go_s", int'(curr_block_start), 16);
    chk("go_e", int'(curr_block_end), 31);

    // reset during EVAL aborts the commit
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    stop_btn = 1'b1; step(); stop_btn = 1'b0;
    chk("pre_abort_busy", int'(busy), 1);
    resetn = 1'b0; step();
    chk("abort_s", int'(curr_block_start), 0);
    chk("abort_e", int'(curr_block_end), 0);
    chk("abort_flags", int'({stop_true, intersect_true, game_over, busy}), 0);
    resetn = 1'b1; step();
    chk("abort_nostb", int'(stop_true), 0);
    chk("abort_idle", int'(busy), 0);

    // random games
    for (int g = 0; g < 10; g++) begin
      do_reset();
      for (int r = 0; r < 6; r++) begin
        row($urandom_range(0, 70), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), h);
        if (!h) break;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
